// File: rtl/scr1_imem_tcm_responder.sv
// Instruction-memory TCM responder: accepts IFU fetches, reads a word-wide RAM and
// returns in-order ok/error responses after a fixed LATENCY-stage pipeline.
module scr1_imem_tcm_responder #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned LATENCY   = 1,
  parameter int unsigned MAX_OUTST = 4,
  localparam int unsigned IDX_W    = $clog2(MEM_WORDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ifu2imem_req_i,
  input  logic             ifu2imem_cmd_i,
  input  logic [31:0]      ifu2imem_addr_i,
  output logic             imem2ifu_req_ack_o,
  output logic [31:0]      imem2ifu_rdata_o,
  output logic [1:0]       imem2ifu_resp_o,
  input  logic             stall_i,
  input  logic             bd_we_i,
  input  logic [IDX_W-1:0] bd_widx_i,
  input  logic [31:0]      bd_wdata_i
);

  localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] WIN_HI = WIN_LO + 33'(MEM_WORDS) * 33'd4;

  logic [31:0]      mem [MEM_WORDS];
  logic [2:0]       outst_cnt;
  logic             hs;
  logic             retire;
  logic             in_win;
  logic             req_err;
  logic [IDX_W-1:0] ram_idx;

  logic [LATENCY-1:0] p_vld;
  logic [LATENCY-1:0] p_err;
  logic [31:0]        p_data [LATENCY];

  // Handshake: a request transfers on a cycle where req and ack are both high.
  // ack never looks at req, and a response retiring this cycle frees its credit
  // only from the next cycle on.
  assign imem2ifu_req_ack_o = rst_n & ~stall_i & (outst_cnt < 3'(MAX_OUTST));
  assign hs                 = ifu2imem_req_i & imem2ifu_req_ack_o;
  assign retire             = p_vld[LATENCY-1];

  always_comb begin
    in_win  = ({1'b0, ifu2imem_addr_i} >= WIN_LO) && ({1'b0, ifu2imem_addr_i} < WIN_HI);
    req_err = ifu2imem_cmd_i | (ifu2imem_addr_i[1:0] != 2'b00) | ~in_win;
    ram_idx = ifu2imem_addr_i[2 +: IDX_W];
  end

  // Preload port; the nonblocking write makes a same-cycle read see the old word.
  always_ff @(posedge clk) begin
    if (bd_we_i) begin
      mem[bd_widx_i] <= bd_wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_vld <= '0;
      p_err <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        p_data[i] <= '0;
      end
    end else begin
      p_vld[0]  <= hs;
      p_err[0]  <= hs & req_err;
      p_data[0] <= (hs && !req_err) ? mem[ram_idx] : 32'h0;
      for (int i = 1; i < LATENCY; i++) begin
        p_vld[i]  <= p_vld[i-1];
        p_err[i]  <= p_err[i-1];
        p_data[i] <= p_data[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outst_cnt <= 3'd0;
    end else if (hs && !retire) begin
      outst_cnt <= outst_cnt + 3'd1;
    end else if (!hs && retire) begin
      outst_cnt <= outst_cnt - 3'd1;
    end
  end

  always_comb begin
    imem2ifu_resp_o  = 2'b00;
    imem2ifu_rdata_o = 32'h0;
    if (p_vld[LATENCY-1]) begin
      if (p_err[LATENCY-1]) begin
        imem2ifu_resp_o = 2'b10;
      end else begin
        imem2ifu_resp_o  = 2'b01;
        imem2ifu_rdata_o = p_data[LATENCY-1];
      end
    end
  end

endmodule

// File: tb/tb_scr1_imem_tcm_responder.sv
// Directed bench for scr1_imem_tcm_responder over three parameter sets (A, B, C),
// with an ordered, cycle-stamped response scoreboard shared by all units.
module tb_scr1_imem_tcm_responder;

  localparam int LAT_A = 2;
  localparam int LAT_B = 3;
  localparam int LAT_C = 4;
  localparam logic [31:0] BASE_C = 32'h8000_0000;
  localparam int W = 52;  // {unit[1:0], due_cycle[15:0], resp[1:0], rdata[31:0]}

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_v   [3];
  logic        cmd_v   [3];
  logic [31:0] addr_v  [3];
  logic        ack_v   [3];
  logic [31:0] rdata_v [3];
  logic [1:0]  resp_v  [3];
  logic        stall_v [3];
  logic        bd_we_v [3];
  logic [3:0]  bd_widx_v [3];
  logic [31:0] bd_wdata_v [3];

  logic [15:0]  cyc = 16'd0;
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 16'd1;

  scr1_imem_tcm_responder #(.MEM_WORDS(16), .BASE_ADDR(32'h0), .LATENCY(LAT_A), .MAX_OUTST(4)) u_a (
    .clk(clk), .rst_n(rst_n),
    .ifu2imem_req_i(req_v[0]), .ifu2imem_cmd_i(cmd_v[0]), .ifu2imem_addr_i(addr_v[0]),
    .imem2ifu_req_ack_o(ack_v[0]), .imem2ifu_rdata_o(rdata_v[0]), .imem2ifu_resp_o(resp_v[0]),
    .stall_i(stall_v[0]), .bd_we_i(bd_we_v[0]), .bd_widx_i(bd_widx_v[0]), .bd_wdata_i(bd_wdata_v[0])
  );

  scr1_imem_tcm_responder #(.MEM_WORDS(16), .BASE_ADDR(32'h0), .LATENCY(LAT_B), .MAX_OUTST(1)) u_b (
    .clk(clk), .rst_n(rst_n),
    .ifu2imem_req_i(req_v[1]), .ifu2imem_cmd_i(cmd_v[1]), .ifu2imem_addr_i(addr_v[1]),
    .imem2ifu_req_ack_o(ack_v[1]), .imem2ifu_rdata_o(rdata_v[1]), .imem2ifu_resp_o(resp_v[1]),
    .stall_i(stall_v[1]), .bd_we_i(bd_we_v[1]), .bd_widx_i(bd_widx_v[1]), .bd_wdata_i(bd_wdata_v[1])
  );

  scr1_imem_tcm_responder #(.MEM_WORDS(16), .BASE_ADDR(BASE_C), .LATENCY(LAT_C), .MAX_OUTST(7)) u_c (
    .clk(clk), .rst_n(rst_n),
    .ifu2imem_req_i(req_v[2]), .ifu2imem_cmd_i(cmd_v[2]), .ifu2imem_addr_i(addr_v[2]),
    .imem2ifu_req_ack_o(ack_v[2]), .imem2ifu_rdata_o(rdata_v[2]), .imem2ifu_resp_o(resp_v[2]),
    .stall_i(stall_v[2]), .bd_we_i(bd_we_v[2]), .bd_widx_i(bd_widx_v[2]), .bd_wdata_i(bd_wdata_v[2])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic int lat_of(input int u);
    return (u == 0) ? LAT_A : (u == 1) ? LAT_B : LAT_C;
  endfunction

  // Scoreboard: every non-idle response must match the oldest expected entry,
  // including the cycle it was due on.
  always @(negedge clk) begin : mon
    logic [W-1:0] e;
    for (int u = 0; u < 3; u++) begin
      if (resp_v[u] != 2'b00) begin
        if (exp_q.size() == 0) begin
          check($sformatf("unexp_rsp%0d", u), {resp_v[u], rdata_v[u]}, 64'h0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("rsp%0d", u), {2'(u), cyc, resp_v[u], rdata_v[u]}, e);
        end
      end
    end
  end

  // One cycle of request drive; entered and left at posedge+1.
  task automatic cyc_req(input int u, input logic cmd, input logic [31:0] addr,
                         input logic exp_ack, input logic [1:0] er, input logic [31:0] ed);
    req_v[u] = 1'b1; cmd_v[u] = cmd; addr_v[u] = addr;
    @(negedge clk);
    check($sformatf("ack%0d", u), ack_v[u], exp_ack);
    if (exp_ack) exp_q.push_back({2'(u), cyc + 16'(lat_of(u)), er, ed});
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int u = 0; u < 3; u++) begin
      req_v[u] = 1'b0; cmd_v[u] = 1'b0; addr_v[u] = 32'h0;
    end
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic bd_write(input int u, input logic [3:0] idx, input logic [31:0] data);
    bd_we_v[u] = 1'b1; bd_widx_v[u] = idx; bd_wdata_v[u] = data;
    @(posedge clk); #1;
    bd_we_v[u] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    for (int u = 0; u < 3; u++) begin
      req_v[u] = 1'b1; cmd_v[u] = 1'b0; addr_v[u] = 32'h0; stall_v[u] = 1'b0;
      bd_we_v[u] = 1'b0; bd_widx_v[u] = 4'd0; bd_wdata_v[u] = 32'h0;
    end
    @(posedge clk); #1;
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      check($sformatf("rst_ack%0d", u), ack_v[u], 1'b0);
      check($sformatf("rst_resp%0d", u), resp_v[u], 2'b00);
      check($sformatf("rst_rdata%0d", u), rdata_v[u], 32'h0);
    end
    @(posedge clk); #1;
    idle(0);

    // Preload while still in reset.
    bd_write(0, 4'd0, 32'h11); bd_write(0, 4'd1, 32'h22);
    bd_write(0, 4'd2, 32'h33); bd_write(0, 4'd3, 32'h44);
    bd_write(0, 4'd5, 32'h55);
    bd_write(1, 4'd0, 32'hB0);
    bd_write(2, 4'd0, 32'hC0); bd_write(2, 4'd1, 32'hC1); bd_write(2, 4'd15, 32'hF00D);
    rst_n = 1'b1;
    idle(1);

    // Back-to-back reads, LATENCY=2.
    cyc_req(0, 1'b0, 32'h0, 1'b1, 2'b01, 32'h11);
    cyc_req(0, 1'b0, 32'h4, 1'b1, 2'b01, 32'h22);
    cyc_req(0, 1'b0, 32'h8, 1'b1, 2'b01, 32'h33);
    cyc_req(0, 1'b0, 32'hC, 1'b1, 2'b01, 32'h44);
    idle(4);

    // Error cases interleaved with a good read.
    cyc_req(0, 1'b0, 32'h2,  1'b1, 2'b10, 32'h0);
    cyc_req(0, 1'b1, 32'h0,  1'b1, 2'b10, 32'h0);
    cyc_req(0, 1'b0, 32'h4,  1'b1, 2'b01, 32'h22);
    cyc_req(0, 1'b0, 32'h40, 1'b1, 2'b10, 32'h0);
    idle(4);

    // Stall holds ack low, first accept after release responds on time.
    stall_v[0] = 1'b1;
    repeat (5) cyc_req(0, 1'b0, 32'h8, 1'b0, 2'b00, 32'h0);
    stall_v[0] = 1'b0;
    cyc_req(0, 1'b0, 32'h8, 1'b1, 2'b01, 32'h33);
    idle(4);

    // Read-before-write on the backdoor, then the new word.
    bd_we_v[0] = 1'b1; bd_widx_v[0] = 4'd5; bd_wdata_v[0] = 32'hDEAD;
    cyc_req(0, 1'b0, 32'h14, 1'b1, 2'b01, 32'h55);
    bd_we_v[0] = 1'b0;
    cyc_req(0, 1'b0, 32'h14, 1'b1, 2'b01, 32'hDEAD);
    idle(4);

    // MAX_OUTST=1, LATENCY=3: ack once every four cycles with req held.
    for (int k = 0; k < 12; k++) begin
      cyc_req(1, 1'b0, 32'h0, (k % 4) == 0, 2'b01, 32'hB0);
      check("outst_b", 64'(u_b.outst_cnt <= 3'd1), 64'd1);
    end
    idle(6);

    // Reset with two requests in flight: both are dropped.
    cyc_req(2, 1'b0, BASE_C,        1'b1, 2'b01, 32'hC0);
    cyc_req(2, 1'b0, BASE_C + 32'h4, 1'b1, 2'b01, 32'hC1);
    exp_q.delete();
    idle(0);
    rst_n = 1'b0;
    req_v[2] = 1'b1; addr_v[2] = BASE_C;
    @(negedge clk);
    check("rst_mid_ack", ack_v[2], 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("post_rst_idle", resp_v[2], 2'b00);
      @(posedge clk); #1;
    end

    // Normal operation after reset, window edges on a non-zero base.
    cyc_req(2, 1'b0, BASE_C + 32'h4,  1'b1, 2'b01, 32'hC1);
    cyc_req(2, 1'b0, BASE_C + 32'h3C, 1'b1, 2'b01, 32'hF00D);
    cyc_req(2, 1'b0, 32'h0000_0004,   1'b1, 2'b10, 32'h0);
    cyc_req(2, 1'b0, BASE_C + 32'h40, 1'b1, 2'b10, 32'h0);
    cyc_req(2, 1'b0, BASE_C + 32'h3E, 1'b1, 2'b10, 32'h0);
    idle(8);

    check("drain", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
